// File: rtl/bus_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the system-bus arbiter and
//               the BusAddressTranslator it drives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    // Arbiter sequencing states
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // device_en value meaning "address decodes to no device"
    localparam logic [7:0] DEV_NONE = 8'h00;

    // Default bus widths shared with BusAddressTranslator
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    // Width of the access timeout counter
    localparam int TO_CNT_W = 16;

    // Index width for a vector of n entries, never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Searches upward from the
//               entry after i_last (wrapping) and returns the first set
//               request as a one-hot winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last,
    output logic [NUM_MASTERS-1:0] o_win,
    output logic                   o_valid
);

    logic [IDX_W-1:0] w_idx;

    // First requester after the last owner, in rotating order
    always_comb begin
        o_win   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = IDX_W'((int'(i_last) + k) % NUM_MASTERS);
            if (!o_valid && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter and transaction sequencer for the shared
//               system bus. Grants one master, registers its address/write
//               data onto the bus and holds the grant until the device acks
//               or the address decodes to no device.
//               Optional access timeout: define BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int DATA_W      = BUS_DATA_W,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        i_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
    input  logic [NUM_MASTERS-1:0]        i_m_we,
    input  logic [NUM_MASTERS*DATA_W-1:0] i_m_wdata,
    output logic [NUM_MASTERS-1:0]        o_grant,
    output logic [NUM_MASTERS-1:0]        o_done,
    output logic [NUM_MASTERS-1:0]        o_err,
    output logic                          o_bus_valid,
    output logic [ADDR_W-1:0]             o_bus_addr,
    output logic                          o_bus_we,
    output logic [DATA_W-1:0]             o_bus_wdata,
    input  logic [7:0]                    i_device_en,
    input  logic                          i_dev_ack
);

    localparam int IDX_W = idx_width(NUM_MASTERS);

    state_t                   r_state,  w_state_nxt;
    logic [NUM_MASTERS-1:0]   r_grant,  w_grant_nxt;
    logic [NUM_MASTERS-1:0]   r_done,   w_done_nxt;
    logic [NUM_MASTERS-1:0]   r_err,    w_err_nxt;
    logic                     r_valid,  w_valid_nxt;
    logic [ADDR_W-1:0]        r_addr,   w_addr_nxt;
    logic                     r_we,     w_we_nxt;
    logic [DATA_W-1:0]        r_wdata,  w_wdata_nxt;
    logic [IDX_W-1:0]         r_last,   w_last_nxt;
    logic [IDX_W-1:0]         r_owner,  w_owner_nxt;

    logic [NUM_MASTERS-1:0]   w_win;
    logic                     w_pick_valid;
    logic [IDX_W-1:0]         w_win_idx;
    logic [ADDR_W-1:0]        w_sel_addr;
    logic                     w_sel_we;
    logic [DATA_W-1:0]        w_sel_wdata;
    logic                     w_end;
    logic                     w_fail;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0]      r_cnt,    w_cnt_nxt;
`else
    logic                     w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_req   (i_req),
        .i_last  (r_last),
        .o_win   (w_win),
        .o_valid (w_pick_valid)
    );

    // Select the winning master's index, address, write enable and data
    always_comb begin
        w_win_idx   = '0;
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_win[i]) begin
                w_win_idx   = IDX_W'(i);
                w_sel_addr  = w_sel_addr  | i_m_addr[i*ADDR_W +: ADDR_W];
                w_sel_we    = w_sel_we    | i_m_we[i];
                w_sel_wdata = w_sel_wdata | i_m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and output logic: grant in IDLE, complete or abort in ACCESS
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_we_nxt    = r_we;
        w_wdata_nxt = r_wdata;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_end       = 1'b0;
        w_fail      = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_ACCESS;
                    w_grant_nxt = w_win;
                    w_valid_nxt = 1'b1;
                    w_addr_nxt  = w_sel_addr;
                    w_we_nxt    = w_sel_we;
                    w_wdata_nxt = w_sel_wdata;
                    w_owner_nxt = w_win_idx;
`ifdef BUS_ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ST_ACCESS: begin
                // Unmapped address beats ack; ack beats timeout
                if (i_device_en == DEV_NONE) begin
                    w_end  = 1'b1;
                    w_fail = 1'b1;
                end else if (i_dev_ack) begin
                    w_end  = 1'b1;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (r_cnt == TO_CNT_W'(TIMEOUT - 1)) begin
                    w_end  = 1'b1;
                    w_fail = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
                if (w_end) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = r_owner;
                    if (w_fail) begin
                        w_err_nxt  = r_grant;
                    end else begin
                        w_done_nxt = r_grant;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; last pointer resets so master 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_last  <= IDX_W'(NUM_MASTERS - 1);
            r_owner <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_we    <= w_we_nxt;
            r_wdata <= w_wdata_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign o_grant     = r_grant;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_bus_valid = r_valid;
    assign o_bus_addr  = r_addr;
    assign o_bus_we    = r_we;
    assign o_bus_wdata = r_wdata;

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
Name:
bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer for the shared system bus.
- Accepts requests from NUM_MASTERS masters and grants the bus to one of them.
- Drives the granted master's virtual address into BusAddressTranslator and checks its device_en output.
- Holds the grant until the selected device acks, the address decodes to no device, or (optionally) a timeout fires; then returns done/err to the master.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- ADDR_W, 32, virtual address width
- DATA_W, 32, write data width
- TIMEOUT, 255, ACCESS cycles allowed before abort (timeout feature only)

Ports:
- clk  in  1  single system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_MASTERS  per-master request, level, held until done/err
- m_addr  in  NUM_MASTERS*ADDR_W  per-master virtual address, master i at bits [i*ADDR_W +: ADDR_W]
- m_we  in  NUM_MASTERS  per-master write enable
- m_wdata  in  NUM_MASTERS*DATA_W  per-master write data
- grant  out  NUM_MASTERS  one-hot current owner
- done  out  NUM_MASTERS  one-cycle completion pulse to the owner
- err  out  NUM_MASTERS  one-cycle error pulse to the owner
- bus_valid  out  1  transaction active on the bus
- bus_addr  out  ADDR_W  virtual address, to BusAddressTranslator.virtual_addr
- bus_we  out  1  registered write enable of the owner
- bus_wdata  out  DATA_W  registered write data of the owner
- device_en  in  8  from BusAddressTranslator, one-hot selected device, 0 = unmapped
- dev_ack  in  1  OR of all device acks

Behaviour:
- Reset (async, rst_n=0):
  - grant, done, err, bus_valid, bus_we = 0; bus_addr, bus_wdata = 0.
  - State = IDLE; last-grant pointer = NUM_MASTERS-1, so master 0 has first priority.
- IDLE:
  - If any req bit is set, pick the first requester searching upward from last+1, modulo NUM_MASTERS.
  - On that edge register grant, bus_addr, bus_we, bus_wdata and set bus_valid=1; go to ACCESS.
  - Latency: req seen at edge N gives grant/bus_valid high after edge N. If no req, all outputs hold at 0.
- ACCESS (bus_valid=1), checked in priority order each cycle:
  - device_en==0: pulse err[owner] on the next edge; go to IDLE.
  - dev_ack=1: pulse done[owner]; go to IDLE.
  - Otherwise: stay in ACCESS.
- Leaving ACCESS:
  - grant and bus_valid clear on the same edge that raises done/err.
  - last pointer = owner.
- The earliest regrant is the cycle after done/err, so the same master can never hold the bus on back-to-back cycles without passing through IDLE.
- Master changes:
  - Owner dropping req during ACCESS is ignored; the transaction completes normally.
  - Changes to m_addr/m_we/m_wdata after grant are ignored (values are registered).
- Simultaneous events:
  - device_en==0 together with dev_ack gives err (error wins).
  - Requests arriving during ACCESS wait; fairness is maintained by the rotating pointer.
- Reset mid-ACCESS: immediate return to the reset values; no done/err pulse is issued.
- done/err are never asserted together, and each is high for exactly one cycle.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to ACCESS and increments each cycle without dev_ack.
  - When it reaches TIMEOUT, pulse err[owner] and go to IDLE.
  - dev_ack on the same cycle as the timeout wins (done).
- Undefined: no counter; ACCESS waits indefinitely for dev_ack.

Decomposition:
- Package bus_pkg holds:
  - state encoding (IDLE=0, ACCESS=1)
  - DEV_NONE = 8'h00
  - default ADDR_W/DATA_W constants shared with BusAddressTranslator
- Sub-module rr_picker: combinational round-robin priority picker.
  - Inputs: req vector and last pointer.
  - Outputs: one-hot winner and valid.

Test Plan:
- Single request: req=4'b0001, m_addr[0]=32'h00000020, device_en=8'h01, ack 3 cycles later.
  - Required: grant=0001 one cycle after req; bus_addr=32'h00000020; done[0] pulse 1 cycle; bus_valid drops on the same edge.
- Round robin: req=4'b1111 held, dev_ack after 1 cycle each.
  - Required: grant order 0001, 0010, 0100, 1000, 0001.
- Unmapped address: m_addr[2]=32'h01000009, bench drives device_en=8'h00.
  - Required: err[2] pulse, no done, returns to IDLE, bus_valid low next cycle.
- Error precedence: device_en=0 and dev_ack=1 on the same cycle.
  - Required: err pulse only.
- Reset mid-ACCESS: rst_n=0 while grant=0010.
  - Required: all outputs 0 immediately; after release, req=4'b0011 is granted to master 0 first.
- Timeout (BUS_ARB_TIMEOUT_EN, TIMEOUT=5): m_addr=32'h008000A0, device_en=8'h02, no ack.
  - Required: err pulse 5 cycles after grant.
- Timeout disabled: same stimulus, no ack.
  - Required: grant still held after 300 cycles.
